// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared definitions for the program counter slice.
//   PC_DEFAULT_WIDTH : default count width.
//   pc_next()        : next-count rule, priority rst > load > increment,
//                      evaluated on 32-bit operands. The caller truncates the
//                      result to its own width, which gives the mod-2^W wrap.
package program_counter_pkg;

  localparam int PC_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] pc_next(input logic [31:0] cur,
                                          input logic [31:0] in,
                                          input logic        load,
                                          input logic        rst);
    logic [31:0] nxt;
    if (rst)       nxt = '0;
    else if (load) nxt = in;
    else           nxt = cur + 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/program_counter_incrementer.sv
// pc_incrementer: combinational BIT_WIDTH-bit +1 adder.
// Ports:
//   a     : value to increment
//   sum   : a + 1 (mod 2^BIT_WIDTH)
//   carry : high when a is all-ones, i.e. the increment wraps to zero
module pc_incrementer
  import program_counter_pkg::*;
#(
  parameter int BIT_WIDTH = PC_DEFAULT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] a,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry
);

  assign {carry, sum} = {1'b0, a} + {{BIT_WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/program_counter.sv
// program_counter: binary up-counter with synchronous parallel load, used as
// the processor's program counter.
// Ports:
//   clk  : system clock, rising-edge active
//   rst  : synchronous active-high reset, clears the count
//   in   : parallel load value (jump/branch target)
//   load : synchronous load strobe, active-high
//   out  : current count, driven straight from the register
//   ovf  : (only with PROGRAM_COUNTER_OVF_EN) one-cycle registered pulse in the
//          cycle where out wrapped from all-ones to zero by incrementing
// Priority on each rising edge: rst > load > increment.
// Optional build macro: PROGRAM_COUNTER_OVF_EN adds the ovf output.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int BIT_WIDTH = PC_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 load,
`ifdef PROGRAM_COUNTER_OVF_EN
  output logic [BIT_WIDTH-1:0] out,
  output logic                 ovf
`else
  output logic [BIT_WIDTH-1:0] out
`endif
);

  logic [BIT_WIDTH-1:0] cnt;
  logic [BIT_WIDTH-1:0] cnt_inc;
  logic                 inc_carry;
  logic [BIT_WIDTH-1:0] cnt_d;

  pc_incrementer #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_inc (
    .a     (cnt),
    .sum   (cnt_inc),
    .carry (inc_carry)
  );

  always_comb begin
    cnt_d = cnt_inc;
    if (rst)       cnt_d = '0;
    else if (load) cnt_d = in;
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_d;
  end

  assign out = cnt;

`ifdef PROGRAM_COUNTER_OVF_EN
  // Pulse only on a genuine increment wrap; a load of zero must not set it.
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ~load & inc_carry;
  end

  assign ovf = ovf_q;
`else
  logic unused_carry;
  assign unused_carry = inc_carry;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (BIT_WIDTH = 4). Expected values come
// from an independent reference model and pass through a scoreboard queue.
module tb_program_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] in;
  logic [W-1:0] out;
`ifdef PROGRAM_COUNTER_OVF_EN
  logic         ovf;
`endif

  int vectors;
  int miscompares;

  logic [W-1:0] m_cnt;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  program_counter #(.BIT_WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .load (load),
`ifdef PROGRAM_COUNTER_OVF_EN
    .out  (out),
    .ovf  (ovf)
`else
    .out  (out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push the model's prediction, then compare
  // the DUT output just after the rising edge.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d, input string tag);
    logic [W-1:0] nxt;
    logic         novf;
    logic [W-1:0] e;
    logic         eo;
    @(negedge clk);
    rst  = r;
    load = l;
    in   = d;
    if (r) begin
      nxt  = '0;
      novf = 1'b0;
    end else if (l) begin
      nxt  = d;
      novf = 1'b0;
    end else begin
      nxt  = (m_cnt == 4'hF) ? 4'h0 : m_cnt + 4'h1;
      novf = (m_cnt == 4'hF);
    end
    m_cnt = nxt;
    exp_q.push_back(nxt);
    exp_ovf_q.push_back(novf);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    chk(tag, {28'd0, out}, {28'd0, e});
`ifdef PROGRAM_COUNTER_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected unknown ovf prediction");
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_cnt       = '0;
    rst         = 1'b1;
    load        = 1'b0;
    in          = '0;

    // Reset hold
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'h5, "reset_hold");
    // Count run 1..10
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'h0, "count_run");
    // Load 2 then count 3
    step(1'b0, 1'b1, 4'b0010, "load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, "load_count");
    // Priority: rst beats load, then load applies
    step(1'b1, 1'b1, 4'b1001, "prio_rst");
    step(1'b0, 1'b1, 4'b1001, "prio_load");
    // Wrap through all-ones
    step(1'b0, 1'b1, 4'b1110, "wrap_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, "wrap_count");
    // Load of all-ones, then wrap
    step(1'b0, 1'b1, 4'hF, "load_ones");
    step(1'b0, 1'b0, 4'h3, "ones_wrap");
    // Load of zero does not pulse ovf
    step(1'b0, 1'b1, 4'h0, "load_zero");
    // Load hold then release
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0111, "load_hold");
    step(1'b0, 1'b0, 4'h0, "load_release");
    // Unknown on in while load is low is ignored
    step(1'b0, 1'b0, 4'bxxxx, "x_in");
    step(1'b0, 1'b0, 4'bxxxx, "x_in");
    // Reset mid-count, then resume from 0
    step(1'b1, 1'b0, 4'h0, "mid_rst");
    step(1'b0, 1'b0, 4'h0, "resume");
    step(1'b0, 1'b0, 4'h0, "resume");
    // Reset held while load toggles
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 4'hC, "rst_vs_load");
    // Reset at all-ones clears ovf path
    step(1'b0, 1'b1, 4'hF, "pre_rst_wrap");
    step(1'b1, 1'b0, 4'h0, "rst_at_ones");
    // Random mix
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] d;
      logic r;
      logic l;
      d = W'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 3) == 0);
      step(r, l, d, "random");
    end

    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
